func_call_server: RTL



---
 rtl/func_call_server_if.sv | 23 ++
 rtl/func_call_server.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/func_call_server_if.sv
// Caller-side bundle for func_call_server: per-caller request handshake and result strobes.
// A call transfers on a cycle where req_valid[i] && req_ready[i]; the caller holds arg/op stable while valid && !ready.
interface func_call_server_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CALLERS = 4
);
    logic [NUM_CALLERS-1:0]            req_valid;
    logic [NUM_CALLERS-1:0]            req_ready;
    logic [NUM_CALLERS*DATA_WIDTH-1:0] req_arg;
    logic [NUM_CALLERS*2-1:0]          req_op;
    logic [NUM_CALLERS-1:0]            rsp_valid;
    logic [NUM_CALLERS*DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_arg, req_op,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_arg, req_op,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/func_call_server.sv
// Shared pipelined function evaluator: round-robin call acceptance, fixed-latency in-order results.
// Optional FUNC_CALL_SERVER_STATS_EN adds a saturating 16-bit accepted-call counter port.
module func_call_server #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CALLERS = 4,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    func_call_server_if.slave  bus
`ifdef FUNC_CALL_SERVER_STATS_EN
    ,
    output logic [15:0]        call_count
`endif
);
    localparam int ID_W = (NUM_CALLERS > 1) ? $clog2(NUM_CALLERS) : 1;

    typedef struct packed {
        logic                  vld;
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] res;
    } stage_t;

    logic [ID_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [NUM_CALLERS-1:0]            grant;
    logic [ID_W-1:0]                   grant_id;
    logic [ID_W-1:0]                   scan_idx;
    int                                scan_sum;
    logic                              accept;
    logic [DATA_WIDTH-1:0]             grant_arg;
    logic [1:0]                        grant_op;
    stage_t                            issue;
    stage_t                            stage_q [LATENCY];
    stage_t                            stage_d [LATENCY];
    logic [NUM_CALLERS*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_CALLERS-1:0]            rsp_valid;

    function automatic logic [DATA_WIDTH-1:0] eval_op(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [1:0] op);
        logic [DATA_WIDTH-1:0] r;
        r = a;
        case (op)
            2'd0: r = a;
            2'd1: r = ~a;
            2'd2: for (int b = 0; b < DATA_WIDTH; b++) r[b] = a[DATA_WIDTH-1-b];
            default: r = {{(DATA_WIDTH-1){1'b0}}, ^a};
        endcase
        return r;
    endfunction

    // Scan from rr_ptr upward with wrap; the first requester found is granted.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        accept   = 1'b0;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_CALLERS; k++) begin
            scan_sum = int'(rr_ptr_q) + k;
            if (scan_sum >= NUM_CALLERS) scan_sum = scan_sum - NUM_CALLERS;
            scan_idx = ID_W'(scan_sum);
            if (!accept && bus.req_valid[scan_idx]) begin
                accept          = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_id        = scan_idx;
            end
        end
    end

    always_comb begin
        grant_arg = '0;
        grant_op  = '0;
        for (int i = 0; i < NUM_CALLERS; i++) begin
            if (grant[i]) begin
                grant_arg = bus.req_arg[i*DATA_WIDTH +: DATA_WIDTH];
                grant_op  = bus.req_op[i*2 +: 2];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (grant_id == ID_W'(NUM_CALLERS - 1)) rr_ptr_d = '0;
            else                                     rr_ptr_d = grant_id + ID_W'(1);
        end
    end

    always_comb begin
        issue.vld = accept;
        issue.id  = grant_id;
        issue.res = eval_op(grant_arg, grant_op);
    end

    // The result register loads on the same edge the last stage fills, so data and strobe coincide.
    always_comb begin
        stage_d[0] = issue;
        for (int k = 1; k < LATENCY; k++) stage_d[k] = stage_q[k-1];
        rsp_data_d = rsp_data_q;
        if (stage_d[LATENCY-1].vld) begin
            for (int i = 0; i < NUM_CALLERS; i++) begin
                if (stage_d[LATENCY-1].id == ID_W'(i))
                    rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = stage_d[LATENCY-1].res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            for (int k = 0; k < LATENCY; k++) stage_q[k] <= stage_d[k];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_CALLERS; i++) begin
            rsp_valid[i] = stage_q[LATENCY-1].vld && (stage_q[LATENCY-1].id == ID_W'(i));
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;

`ifdef FUNC_CALL_SERVER_STATS_EN
    logic [15:0] call_count_q, call_count_d;

    always_comb begin
        call_count_d = call_count_q;
        if (accept && call_count_q != 16'hFFFF) call_count_d = call_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) call_count_q <= '0;
        else     call_count_q <= call_count_d;
    end

    assign call_count = call_count_q;
`endif
endmodule
